spectrum_bars: RTL and testbench

Downstream of the complex magnitude estimator: consumes one frame of N per-bin magnitudes (WIDTH+1 bits each, held stable by upstream), folds the lower half-spectrum into BARS display bars, and applies peak-hold with linear decay. Each bar takes the max magnitude in its bin group, is scaled and saturated to a bar height, then registered. Output feeds the display renderer.

---
 rtl/spectrum_bars_pkg.sv | 17 +
 rtl/spectrum_bars_peak.sv | 24 ++
 rtl/spectrum_bars.sv | 102 ++++++++++
 tb/tb_spectrum_bars.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/spectrum_bars_pkg.sv
// Shared types and helpers for the spectrum bar display pipeline.
package spectrum_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  // Right-shift a magnitude and clamp it to the full-scale bar height.
  function automatic logic [31:0] sat_shift(input logic [31:0] mag,
                                            input int unsigned shift,
                                            input int unsigned hw);
    logic [31:0] lvl;
    logic [31:0] full;
    lvl  = mag >> shift;
    full = (32'd1 << hw) - 32'd1;
    return (lvl > full) ? full : lvl;
  endfunction

endpackage

// File: rtl/spectrum_bars_peak.sv
// Peak-hold / linear-decay cell: one instance is time-shared by all bars.
module bar_peak_decay
  import spectrum_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int HEIGHT_W = 5,
  parameter int SH_W     = 5
) (
  input  logic [WIDTH:0]    cand_i,
  input  logic [SH_W-1:0]   shift_i,
  input  logic [HEIGHT_W-1:0] old_i,
  output logic [HEIGHT_W-1:0] new_o
);

  logic [31:0] lvl;

  // New level wins on ties or rises; otherwise fall by one (old > lvl >= 0, so no underflow).
  always_comb begin
    lvl = sat_shift(32'(cand_i), 32'(shift_i), HEIGHT_W);
    if (lvl >= 32'(old_i)) new_o = HEIGHT_W'(lvl);
    else                   new_o = old_i - 1'b1;
  end

endmodule

// File: rtl/spectrum_bars.sv
// Folds the lower half-spectrum into bars, one bin per cycle, with peak-hold decay.
module spectrum_bars
  import spectrum_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int N        = 256,
  parameter int BARS     = 16,
  parameter int HEIGHT_W = 5,
  parameter int SKIP_DC  = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH:0]               magnitude [0:N-1],
  input  logic [$clog2(WIDTH+1)-1:0]   scale_shift,
  input  logic                         frame_valid,
  output logic                         frame_ready,
  output logic [HEIGHT_W-1:0]          bar_height [0:BARS-1],
  output logic                         bars_valid
);

  localparam int USE_BINS = N / 2;
  localparam int GROUP    = USE_BINS / BARS;
  localparam int IDX_W    = $clog2(USE_BINS);
  localparam int BAR_W    = (BARS > 1) ? $clog2(BARS) : 1;
  localparam int SH_W     = $clog2(WIDTH + 1);
  localparam int RD_W     = $clog2(N);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q;
  logic [WIDTH:0]       grp_max_q;
  logic [SH_W-1:0]      shift_q;
  logic [HEIGHT_W-1:0]  bar_q [0:BARS-1];

  logic [RD_W-1:0]      rd_idx;
  logic [WIDTH:0]       bin, cand;
  logic                 group_end;
  logic [BAR_W-1:0]     bar_sel;
  logic [HEIGHT_W-1:0]  new_h;

  // Current bin, running group max and which bar (if any) closes this cycle.
  always_comb begin
    rd_idx    = RD_W'(idx_q);
    bin       = (SKIP_DC != 0 && idx_q == '0) ? '0 : magnitude[rd_idx];
    cand      = (bin > grp_max_q) ? bin : grp_max_q;
    group_end = (idx_q % IDX_W'(GROUP)) == IDX_W'(GROUP - 1);
    bar_sel   = BAR_W'(idx_q / IDX_W'(GROUP));
  end

  bar_peak_decay #(.WIDTH(WIDTH), .HEIGHT_W(HEIGHT_W), .SH_W(SH_W)) u_peak (
    .cand_i  (cand),
    .shift_i (shift_q),
    .old_i   (bar_q[bar_sel]),
    .new_o   (new_h)
  );

  // Next state and handshake outputs.
  always_comb begin
    state_d     = state_q;
    frame_ready = (state_q == IDLE);
    bars_valid  = (state_q == DONE);
    case (state_q)
      IDLE:    if (frame_valid) state_d = SCAN;
      SCAN:    if (idx_q == IDX_W'(USE_BINS - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Scan counter, group max and latched shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      grp_max_q <= '0;
      shift_q   <= '0;
    end else if (state_q == IDLE && frame_valid) begin
      idx_q     <= '0;
      grp_max_q <= '0;
      shift_q   <= scale_shift;
    end else if (state_q == SCAN) begin
      idx_q     <= idx_q + 1'b1;
      grp_max_q <= group_end ? '0 : cand;
    end
  end

  // Bar heights move only when a group closes during the scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < BARS; b++) bar_q[b] <= '0;
    end else if (state_q == SCAN && group_end) begin
      bar_q[bar_sel] <= new_h;
    end
  end

  assign bar_height = bar_q;

endmodule

// File: tb/tb_spectrum_bars.sv
module tb_spectrum_bars;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [16:0] magnitude [0:255];
  logic [4:0]  scale_shift = '0;
  logic        frame_valid = 1'b0;
  logic        frame_ready;
  logic [4:0]  bar_height [0:15];
  logic        bars_valid;

  int checks = 0;
  int failures = 0;

  spectrum_bars dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .magnitude   (magnitude),
    .scale_shift (scale_shift),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .bar_height  (bar_height),
    .bars_valid  (bars_valid)
  );

  always #5 clk = ~clk;

  task automatic clear_mag();
    for (int i = 0; i < 256; i++) magnitude[i] = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Accept one frame and return cycles from accept edge to bars_valid (-1 on timeout).
  task automatic run_frame(output int lat);
    int n;
    lat = -1;
    n = 0;
    while (!frame_ready && n < 300) begin @(posedge clk); #1; n++; end
    frame_valid = 1'b1;
    @(posedge clk); #1;
    frame_valid = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk); #1;
      if (bars_valid) begin lat = i; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int nz;
    do_reset();
    nz = 0;
    for (int b = 0; b < 16; b++) if (bar_height[b] !== 5'd0) nz++;
    checks++;
    if (nz != 0) begin failures++; $display("FAIL reset_bars: %0d nonzero bars, want 0", nz); end
    checks++;
    if (frame_ready !== 1'b1 || bars_valid !== 1'b0) begin
      failures++; $display("FAIL reset_hs: ready=%b valid=%b, want 1 0", frame_ready, bars_valid);
    end
    checks++;
    if ($isunknown({frame_ready, bars_valid}) || $isunknown(bar_height[0]) || $isunknown(bar_height[15])) begin
      failures++; $display("FAIL reset_x: X on outputs");
    end
  endtask

  task automatic test_single_peak();
    int lat, nz;
    clear_mag(); magnitude[9] = 17'd640; scale_shift = 5'd5;
    run_frame(lat);
    checks++;
    if (lat != 128) begin failures++; $display("FAIL peak_latency: got %0d want 128", lat); end
    checks++;
    if (bar_height[1] !== 5'd20) begin failures++; $display("FAIL peak_bar1: got %0d want 20", bar_height[1]); end
    nz = 0;
    for (int b = 0; b < 16; b++) if (b != 1 && bar_height[b] !== 5'd0) nz++;
    checks++;
    if (nz != 0) begin failures++; $display("FAIL peak_others: %0d nonzero want 0", nz); end
    checks++;
    if (bars_valid !== 1'b0 || frame_ready !== 1'b1) begin
      failures++; $display("FAIL peak_pulse: valid=%b ready=%b want 0 1", bars_valid, frame_ready);
    end
    // Same frame again: tie keeps the height.
    run_frame(lat);
    checks++;
    if (bar_height[1] !== 5'd20) begin failures++; $display("FAIL peak_tie: got %0d want 20", bar_height[1]); end
  endtask

  task automatic test_decay();
    int lat;
    logic [4:0] exp_h;
    clear_mag(); scale_shift = 5'd5;
    for (int k = 1; k <= 25; k++) begin
      run_frame(lat);
      exp_h = (k >= 20) ? 5'd0 : 5'(20 - k);
      checks++;
      if (bar_height[1] !== exp_h || lat != 128) begin
        failures++; $display("FAIL decay_%0d: bar1=%0d lat=%0d want %0d 128", k, bar_height[1], lat, exp_h);
      end
    end
    do_reset();
    clear_mag(); magnitude[9] = 17'd640;
    run_frame(lat);
    clear_mag();
    for (int k = 0; k < 8; k++) run_frame(lat);
    checks++;
    if (bar_height[1] !== 5'd12) begin failures++; $display("FAIL decay_to12: got %0d want 12", bar_height[1]); end
    magnitude[9] = 17'd320;
    run_frame(lat);
    checks++;
    if (bar_height[1] !== 5'd11) begin failures++; $display("FAIL decay_below: got %0d want 11", bar_height[1]); end
  endtask

  task automatic test_saturation();
    int lat, nz;
    do_reset();
    clear_mag();
    magnitude[20] = 17'h1FFFF; magnitude[0] = 17'd1000; magnitude[200] = 17'd5000;
    scale_shift = 5'd0;
    run_frame(lat);
    checks++;
    if (bar_height[2] !== 5'd31) begin failures++; $display("FAIL sat_bar2: got %0d want 31", bar_height[2]); end
    checks++;
    if (bar_height[0] !== 5'd0) begin failures++; $display("FAIL dc_bar0: got %0d want 0", bar_height[0]); end
    nz = 0;
    for (int b = 0; b < 16; b++) if (b != 2 && bar_height[b] !== 5'd0) nz++;
    checks++;
    if (nz != 0) begin failures++; $display("FAIL upper_half: %0d nonzero want 0", nz); end
  endtask

  task automatic test_back_to_back();
    int first, second, third, nready;
    clear_mag();
    first = -1; second = -1; third = -1; nready = 0;
    frame_valid = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (frame_ready) begin
        nready++;
        if (first < 0) first = c;
        else if (second < 0) second = c;
        else if (third < 0) third = c;
      end
    end
    frame_valid = 1'b0;
    checks++;
    if (second - first != 130 || third - second != 130) begin
      failures++; $display("FAIL b2b_spacing: %0d %0d want 130 130", second - first, third - second);
    end
    checks++;
    if (nready != 3) begin failures++; $display("FAIL b2b_ready_cycles: got %0d want 3", nready); end
    // Pulses while busy must not queue a frame.
    while (!frame_ready) @(negedge clk);
    frame_valid = 1'b1; @(posedge clk); #1; frame_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); frame_valid = (c % 3 == 0);
    end
    frame_valid = 1'b0;
    nready = 0;
    for (int c = 0; c < 140; c++) begin @(negedge clk); if (frame_ready) nready++; end
    checks++;
    if (nready < 20) begin failures++; $display("FAIL scan_pulse_ignored: idle cycles %0d want >=20", nready); end
  endtask

  task automatic test_reset_mid_scan();
    int lat, nz, seen;
    do_reset();
    clear_mag(); magnitude[9] = 17'd640; scale_shift = 5'd5;
    frame_valid = 1'b1; @(posedge clk); #1; frame_valid = 1'b0;
    repeat (59) @(posedge clk);
    #2 rst_n = 1'b0; #1;
    nz = 0;
    for (int b = 0; b < 16; b++) if (bar_height[b] !== 5'd0) nz++;
    checks++;
    if (nz != 0 || frame_ready !== 1'b1 || bars_valid !== 1'b0) begin
      failures++; $display("FAIL mid_reset: nz=%0d ready=%b valid=%b want 0 1 0", nz, frame_ready, bars_valid);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 150; c++) begin @(negedge clk); if (bars_valid) seen++; end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL mid_reset_novalid: got %0d pulses want 0", seen); end
    run_frame(lat);
    checks++;
    if (bar_height[1] !== 5'd20 || lat != 128) begin
      failures++; $display("FAIL mid_reset_next: bar1=%0d lat=%0d want 20 128", bar_height[1], lat);
    end
  endtask

  initial begin
    clear_mag();
    test_reset();
    test_single_peak();
    test_decay();
    test_saturation();
    test_back_to_back();
    test_reset_mid_scan();
    test_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
